exc_ctrl_unit: RTL and testbench
================================

# exc_ctrl_unit

Exception/interrupt front end sitting directly upstream of the COP0 register file. Synchronizes and latches peripheral interrupt lines into the pending vector that COP0 masks. Arbitrates those interrupts against synchronous pipeline exceptions and runs a flush handshake with the pipeline. Then issues the single-cycle exception commit (occurred, code, branch-delay flag, EPC) that COP0 records, plus a PC redirect to the handler vector.

## Interface
- NUM_IRQ, 7: hardware interrupt lines; they map to pending bits [NUM_IRQ-1:0]. Bit 7 is reserved for the COP0 timer and is driven 0.
- SYNC_STAGES, 2: synchronizer flops per interrupt line (≥2).
- EXC_VECTOR, 32'h80000180: handler address driven on oHandlerAddr.
- iCLK  in  1  sole clock.
- iCLR_n  in  1  reset, asynchronous, active-low.
- iIrq  in  NUM_IRQ  asynchronous level-high interrupt requests.
- iIrqAck  in  NUM_IRQ  synchronous one-hot pulses clearing pending bits (peripheral bus).
- iInterruptMask  in  8  COP0 masked-interrupt vector (already gated by IE).
- iExcLevel  in  1  COP0 SR.EL.
- iExcReq  in  1  synchronous exception request level from pipeline; held until oPCRedirect.
- iExcReqCode  in  5  ExcCode of iExcReq (nonzero).
- iInstrPC  in  32  PC of the instruction at the exception point.
- iInBranchDelay  in  1  that instruction occupies a branch delay slot.
- iFlushAck  in  1  pipeline has squashed younger instructions.
- oPendingInterrupt  out  8  {1'b0, pending[6:0]} to COP0.
- oFlushReq  out  1  flush request.
- oExcOccurred  out  1  one-cycle commit pulse to COP0.
- oExcCode  out  5  captured code (0 = interrupt).
- oBranchDelay  out  1  captured BD flag.
- oEPC  out  32  captured EPC, selected onto COP0 write data during commit.
- oPCRedirect  out  1  one-cycle pulse, coincident with oExcOccurred.
- oHandlerAddr  out  32  constant EXC_VECTOR.

## Operation
- Per line: SYNC_STAGES-flop synchronizer, then a rising-edge detector; an edge sets pending[i].
- iIrqAck[i] clears pending[i]. If an edge and an ack hit the same cycle, set wins.
- Interrupt trigger: state IDLE, |iInterruptMask = 1, and iExcLevel = 0.
- Sync trigger: state IDLE and iExcReq = 1. Not gated by iExcLevel.
- If both triggers are present, the sync trigger wins.
- Capture at trigger:
  - oExcCode = iExcReqCode for a sync trigger, 0 for an interrupt.
  - oBranchDelay = iInBranchDelay.
  - oEPC = iInBranchDelay ? iInstrPC − 4 : iInstrPC, 32-bit wrap.
- FSM states:
  - IDLE: on trigger, capture and go to FLUSH.
  - FLUSH: oFlushReq = 1; go to COMMIT on iFlushAck.
  - COMMIT: oExcOccurred = oPCRedirect = 1 for exactly one cycle; go to WAIT_EL.
  - WAIT_EL: stay until iExcLevel = 1, then go to IDLE.
- Triggers outside IDLE are ignored and are not queued. Pending bits keep accumulating.
- Captured fields hold their values until the next capture.

## Timing
- Reset (asynchronous, any state): state IDLE, pending, synchronizers and edge registers = 0. All outputs 0 except oHandlerAddr = EXC_VECTOR.
- Interrupt latency: an iIrq rise is visible on oPendingInterrupt SYNC_STAGES+1 edges later.
- Flush request: trigger sampled at edge N gives oFlushReq = 1 from N+1.
- Commit: iFlushAck sampled high at edge M gives the commit pulse in cycle M+1. iFlushAck already high when FLUSH is entered gives a minimum of 2 cycles from trigger to commit.
- All outputs are registered; no combinational input-to-output paths.
- Reset deasserted mid-FLUSH: pipeline sees oFlushReq drop; the request is lost. A held iExcReq retriggers.

## Structure
- Shared package cop0_pkg: FSM state enum, ExcCode constants (INT = 0, ADEL = 4, ADES = 5, SYS = 8, BP = 9, RI = 10, OV = 12), EXC_VECTOR default. COP0 also uses this package.
- One sub-module, irq_sync_edge: per-line synchronizer plus edge detector, instantiated NUM_IRQ times.

## Test plan
- Reset, then iIrq[0] rise with mask bit 0 and EL = 0:
  - pending[0] visible 3 edges after the rise.
  - oFlushReq asserted; iFlushAck given 2 cycles later.
  - One-cycle commit with code 0; EPC = iInstrPC = 32'h00400010.
- iExcReq with code 12 and iInterruptMask = 8'h01 in the same cycle: commit code 12; interrupt not taken until WAIT_EL → IDLE with EL = 0.
- iInBranchDelay = 1, iInstrPC = 32'h00400024, sync code 10: oEPC = 32'h00400020, oBranchDelay = 1.
- iIrq[3] edge and iIrqAck[3] in the same cycle: pending[3] = 1. Ack alone next cycle: pending[3] = 0.
- iExcLevel = 1 and mask = 8'h04: no trigger. Drop EL to 0: FLUSH next cycle.
- Assert iCLR_n low during FLUSH: all outputs 0 immediately. After release: IDLE, pending = 0.

Source files
------------

// File: rtl/cop0_pkg.sv
// Shared COP0 definitions: exception FSM states, ExcCode values and the handler vector.
// Used by the exception front end and by the COP0 register file.
package cop0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_WAIT_EL = 2'd3
    } excState_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

    // A faulting delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epcOf(input logic [31:0] pc, input logic inDelaySlot);
        return inDelaySlot ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-flop synchronizer followed by a rising-edge detector.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iCLK,
    input  logic iCLR_n,
    input  logic iIrq,
    output logic oRise
);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   prevLevel;

    always_ff @(posedge iCLK or negedge iCLR_n) begin
        if (!iCLR_n) begin
            syncChain <= '0;
            prevLevel <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], iIrq};
            prevLevel <= syncChain[SYNC_STAGES-1];
        end
    end

    assign oRise = syncChain[SYNC_STAGES-1] & ~prevLevel;

endmodule

// File: rtl/exc_ctrl_unit.sv
// Exception/interrupt front end for COP0: latches interrupt edges, arbitrates against
// pipeline exceptions, handshakes a pipeline flush and issues the one-cycle commit.
module exc_ctrl_unit
    import cop0_pkg::*;
#(
    parameter int          NUM_IRQ     = 7,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT
) (
    input  logic               iCLK,
    input  logic               iCLR_n,
    input  logic [NUM_IRQ-1:0] iIrq,
    input  logic [NUM_IRQ-1:0] iIrqAck,
    input  logic [7:0]         iInterruptMask,
    input  logic               iExcLevel,
    input  logic               iExcReq,
    input  logic [4:0]         iExcReqCode,
    input  logic [31:0]        iInstrPC,
    input  logic               iInBranchDelay,
    input  logic               iFlushAck,
    output logic [7:0]         oPendingInterrupt,
    output logic               oFlushReq,
    output logic               oExcOccurred,
    output logic [4:0]         oExcCode,
    output logic               oBranchDelay,
    output logic [31:0]        oEPC,
    output logic               oPCRedirect,
    output logic [31:0]        oHandlerAddr
);

    logic [NUM_IRQ-1:0] irqRise;
    logic [NUM_IRQ-1:0] pending;
    excState_t          stateQ, stateNext;
    logic               captureEn;
    logic               captureSync;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : gIrq
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSync (
            .iCLK   (iCLK),
            .iCLR_n (iCLR_n),
            .iIrq   (iIrq[i]),
            .oRise  (irqRise[i])
        );
    end

    // A fresh edge beats a simultaneous acknowledge so no interrupt is lost.
    always_ff @(posedge iCLK or negedge iCLR_n) begin
        if (!iCLR_n) begin
            pending <= '0;
        end else begin
            pending <= irqRise | (pending & ~iIrqAck);
        end
    end

    always_comb begin
        oPendingInterrupt = '0;
        oPendingInterrupt[NUM_IRQ-1:0] = pending;
    end

    always_ff @(posedge iCLK or negedge iCLR_n) begin
        if (!iCLR_n) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Synchronous exceptions take priority and ignore SR.EL; triggers only count in IDLE.
    always_comb begin
        stateNext   = stateQ;
        captureEn   = 1'b0;
        captureSync = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (iExcReq) begin
                    captureEn   = 1'b1;
                    captureSync = 1'b1;
                    stateNext   = ST_FLUSH;
                end else if ((|iInterruptMask) && !iExcLevel) begin
                    captureEn = 1'b1;
                    stateNext = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (iFlushAck) begin
                    stateNext = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                stateNext = ST_WAIT_EL;
            end
            ST_WAIT_EL: begin
                if (iExcLevel) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iCLR_n) begin
        if (!iCLR_n) begin
            oExcCode     <= '0;
            oBranchDelay <= 1'b0;
            oEPC         <= '0;
        end else if (captureEn) begin
            oExcCode     <= captureSync ? iExcReqCode : EXC_INT;
            oBranchDelay <= iInBranchDelay;
            oEPC         <= epcOf(iInstrPC, iInBranchDelay);
        end
    end

    assign oFlushReq    = (stateQ == ST_FLUSH);
    assign oExcOccurred = (stateQ == ST_COMMIT);
    assign oPCRedirect  = (stateQ == ST_COMMIT);
    assign oHandlerAddr = EXC_VECTOR;

endmodule

// File: tb/tb_exc_ctrl_unit.sv
// Directed self-checking bench for exc_ctrl_unit; the bench plays both pipeline and COP0.
module tb_exc_ctrl_unit;

    logic        iCLK = 1'b0;
    logic        iCLR_n;
    logic [6:0]  iIrq;
    logic [6:0]  iIrqAck;
    logic [7:0]  iInterruptMask;
    logic        iExcLevel;
    logic        iExcReq;
    logic [4:0]  iExcReqCode;
    logic [31:0] iInstrPC;
    logic        iInBranchDelay;
    logic        iFlushAck;
    logic [7:0]  oPendingInterrupt;
    logic        oFlushReq;
    logic        oExcOccurred;
    logic [4:0]  oExcCode;
    logic        oBranchDelay;
    logic [31:0] oEPC;
    logic        oPCRedirect;
    logic [31:0] oHandlerAddr;

    int compared   = 0;
    int mismatched = 0;

    exc_ctrl_unit dut (
        .iCLK              (iCLK),
        .iCLR_n            (iCLR_n),
        .iIrq              (iIrq),
        .iIrqAck           (iIrqAck),
        .iInterruptMask    (iInterruptMask),
        .iExcLevel         (iExcLevel),
        .iExcReq           (iExcReq),
        .iExcReqCode       (iExcReqCode),
        .iInstrPC          (iInstrPC),
        .iInBranchDelay    (iInBranchDelay),
        .iFlushAck         (iFlushAck),
        .oPendingInterrupt (oPendingInterrupt),
        .oFlushReq         (oFlushReq),
        .oExcOccurred      (oExcOccurred),
        .oExcCode          (oExcCode),
        .oBranchDelay      (oBranchDelay),
        .oEPC              (oEPC),
        .oPCRedirect       (oPCRedirect),
        .oHandlerAddr      (oHandlerAddr)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_pend"},  32'(oPendingInterrupt), 32'h0);
        checkOutput({tag, "_flush"}, 32'(oFlushReq),         32'h0);
        checkOutput({tag, "_occ"},   32'(oExcOccurred),      32'h0);
        checkOutput({tag, "_redir"}, 32'(oPCRedirect),       32'h0);
        checkOutput({tag, "_code"},  32'(oExcCode),          32'h0);
        checkOutput({tag, "_bd"},    32'(oBranchDelay),      32'h0);
        checkOutput({tag, "_epc"},   oEPC,                   32'h0);
        checkOutput({tag, "_vec"},   oHandlerAddr,           32'h8000_0180);
    endtask

    initial begin
        iCLR_n = 1'b0; iIrq = '0; iIrqAck = '0; iInterruptMask = '0; iExcLevel = 1'b0;
        iExcReq = 1'b0; iExcReqCode = '0; iInstrPC = '0; iInBranchDelay = 1'b0; iFlushAck = 1'b0;

        // Reset values
        tick(); tick();
        checkIdleOutputs("reset");
        iCLR_n = 1'b1;
        tick();

        // Interrupt on line 0: latency, flush handshake, commit
        iInstrPC = 32'h0040_0010;
        iIrq[0] = 1'b1;
        tick();
        tick();
        checkOutput("irq0_lat2", 32'(oPendingInterrupt), 32'h00);
        tick();
        checkOutput("irq0_lat3", 32'(oPendingInterrupt), 32'h01);
        iInterruptMask = 8'h01;
        tick();
        checkOutput("irq0_flush", 32'(oFlushReq), 32'h1);
        checkOutput("irq0_noocc", 32'(oExcOccurred), 32'h0);
        tick();
        checkOutput("irq0_flush2", 32'(oFlushReq), 32'h1);
        iFlushAck = 1'b1;
        tick();
        checkOutput("irq0_occ", 32'(oExcOccurred), 32'h1);
        checkOutput("irq0_redir", 32'(oPCRedirect), 32'h1);
        checkOutput("irq0_flushdrop", 32'(oFlushReq), 32'h0);
        checkOutput("irq0_code", 32'(oExcCode), 32'h0);
        checkOutput("irq0_epc", oEPC, 32'h0040_0010);
        checkOutput("irq0_bd", 32'(oBranchDelay), 32'h0);
        iFlushAck = 1'b0;
        tick();
        checkOutput("irq0_pulse1", 32'(oExcOccurred), 32'h0);
        iExcLevel = 1'b1; iInterruptMask = 8'h00; iIrqAck[0] = 1'b1; iIrq[0] = 1'b0;
        tick();
        checkOutput("irq0_ackclr", 32'(oPendingInterrupt), 32'h00);
        iIrqAck = '0; iExcLevel = 1'b0;
        tick();

        // Sync exception beats a simultaneous interrupt; interrupt waits for EL return
        iExcReq = 1'b1; iExcReqCode = 5'd12; iInterruptMask = 8'h01; iInstrPC = 32'h0040_0030;
        tick();
        checkOutput("ov_flush", 32'(oFlushReq), 32'h1);
        iFlushAck = 1'b1;
        tick();
        checkOutput("ov_occ", 32'(oExcOccurred), 32'h1);
        checkOutput("ov_code", 32'(oExcCode), 32'd12);
        checkOutput("ov_epc", oEPC, 32'h0040_0030);
        iExcReq = 1'b0; iFlushAck = 1'b0;
        tick();
        tick();
        checkOutput("ov_waitel_noflush", 32'(oFlushReq), 32'h0);
        checkOutput("ov_waitel_noocc", 32'(oExcOccurred), 32'h0);
        iExcLevel = 1'b1;
        tick();
        checkOutput("ov_idle_el1", 32'(oFlushReq), 32'h0);
        iExcLevel = 1'b0;
        tick();
        checkOutput("ov_int_flush", 32'(oFlushReq), 32'h1);
        iFlushAck = 1'b1;
        tick();
        checkOutput("ov_int_occ", 32'(oExcOccurred), 32'h1);
        checkOutput("ov_int_code", 32'(oExcCode), 32'h0);
        iFlushAck = 1'b0; iInterruptMask = 8'h00; iExcLevel = 1'b1;
        tick();
        tick();
        iExcLevel = 1'b0;

        // Branch-delay exception: EPC backs up one word
        iExcReq = 1'b1; iExcReqCode = 5'd10; iInstrPC = 32'h0040_0024; iInBranchDelay = 1'b1;
        tick();
        checkOutput("ri_flush", 32'(oFlushReq), 32'h1);
        iFlushAck = 1'b1;
        tick();
        checkOutput("ri_occ", 32'(oExcOccurred), 32'h1);
        checkOutput("ri_code", 32'(oExcCode), 32'd10);
        checkOutput("ri_epc", oEPC, 32'h0040_0020);
        checkOutput("ri_bd", 32'(oBranchDelay), 32'h1);
        iExcReq = 1'b0; iFlushAck = 1'b0; iInBranchDelay = 1'b0; iInstrPC = 32'h0;
        tick();
        checkOutput("ri_hold_epc", oEPC, 32'h0040_0020);
        checkOutput("ri_hold_bd", 32'(oBranchDelay), 32'h1);
        iExcLevel = 1'b1;
        tick();
        iExcLevel = 1'b0;

        // Edge and ack on line 3 in the same cycle: set wins, then ack alone clears
        iIrq[3] = 1'b1;
        tick();
        tick();
        iIrqAck[3] = 1'b1;
        tick();
        checkOutput("irq3_setwins", 32'(oPendingInterrupt), 32'h08);
        tick();
        checkOutput("irq3_ackclr", 32'(oPendingInterrupt), 32'h00);
        iIrqAck = '0; iIrq[3] = 1'b0;

        // EL blocks interrupt trigger; dropping EL starts the flush next cycle
        iExcLevel = 1'b1; iInterruptMask = 8'h04; iIrq[5] = 1'b1;
        iInstrPC = 32'h0000_0100; iInBranchDelay = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("el_noflush", 32'(oFlushReq), 32'h0);
        checkOutput("el_pend5", 32'(oPendingInterrupt), 32'h20);
        iExcLevel = 1'b0;
        tick();
        checkOutput("el_flush", 32'(oFlushReq), 32'h1);

        // Asynchronous reset mid-FLUSH clears everything without a clock edge
        #3;
        iCLR_n = 1'b0;
        #1;
        checkIdleOutputs("rstflush");
        iIrq = '0; iInterruptMask = 8'h00; iInBranchDelay = 1'b0;
        tick();
        iCLR_n = 1'b1;
        tick();
        checkOutput("postrst_flush", 32'(oFlushReq), 32'h0);
        checkOutput("postrst_pend", 32'(oPendingInterrupt), 32'h00);
        checkOutput("postrst_occ", 32'(oExcOccurred), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
